lsu_misalign_sequencer: RTL

Load/store sequencer that sits directly upstream of the data memory in the RV32I CPU's memory stage. It accepts one load or store request at a time over a valid/ready handshake and drives the data memory port. Naturally aligned accesses are forwarded as a single access. Misaligned halfword and word accesses are split into sequential byte accesses, because the data memory rejects them. It returns load data, already extended, with a one-cycle response pulse.

---
 rtl/lsu_misalign_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_misalign_sequencer.sv
// Memory-stage load/store sequencer: forwards aligned accesses to the data memory
// in one beat and splits misaligned half/word accesses into little-endian byte beats.
module lsu_misalign_sequencer #(
  parameter int DATA_WIDTH       = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_sign_ext,
  input  logic [DATA_WIDTH-1:0] i_req_address,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_fault,
  output logic                  o_mem_enable_write,
  output logic                  o_mem_enable_read,
  output logic [1:0]            o_mem_size,
  output logic                  o_mem_sign_ext,
  output logic [DATA_WIDTH-1:0] o_mem_address,
  output logic [DATA_WIDTH-1:0] o_mem_data_to_write,
  input  logic [DATA_WIDTH-1:0] i_mem_data_read,
  input  logic                  i_mem_misaligned
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_sign;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [1:0]            r_beat;
  logic [1:0]            r_last;
  logic                  r_byte_mode;
  logic                  r_fault;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_fault;

  logic                  w_req_aligned;
  logic                  w_req_fault;
  logic [DATA_WIDTH-1:0] w_acc_next;
  logic                  w_fault_next;
  logic                  w_last_beat;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_mem_en_w;
  logic                  w_mem_en_r;
  logic [1:0]            w_mem_size;
  logic                  w_mem_sign;
  logic [DATA_WIDTH-1:0] w_mem_address;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  // Classify the incoming request: natural alignment and immediate-fault cases.
  always_comb begin
    w_req_aligned = 1'b0;
    case (i_req_size)
      2'b00:   w_req_aligned = 1'b1;
      2'b01:   w_req_aligned = ~i_req_address[0];
      2'b10:   w_req_aligned = (i_req_address[1:0] == 2'b00);
      default: w_req_aligned = 1'b0;
    endcase
    w_req_fault = (i_req_size == 2'b11) || (!w_req_aligned && !SPLIT_MISALIGNED);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, memory port drive and per-beat accumulator/fault update.
  always_comb begin
    w_state_next  = r_state;
    w_acc_next    = r_acc;
    w_fault_next  = r_fault;
    w_last_beat   = 1'b0;
    w_mem_en_w    = 1'b0;
    w_mem_en_r    = 1'b0;
    w_mem_size    = 2'b00;
    w_mem_sign    = 1'b0;
    w_mem_address = {DATA_WIDTH{1'b0}};
    w_mem_wdata   = {DATA_WIDTH{1'b0}};
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_state_next = w_req_fault ? S_RESP : S_ACCESS;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_ACCESS: begin
        w_fault_next = r_fault | i_mem_misaligned;
        w_mem_en_w   = r_write;
        w_mem_en_r   = ~r_write;
        if (r_byte_mode) begin
          // Byte beats walk upward from the request address and wrap at 2^32.
          w_mem_address = r_addr + {{(DATA_WIDTH-2){1'b0}}, r_beat};
          w_mem_wdata   = {{(DATA_WIDTH-8){1'b0}}, r_wdata[{r_beat, 3'b000} +: 8]};
          if (!r_write) begin
            w_acc_next[{r_beat, 3'b000} +: 8] = i_mem_data_read[7:0];
          end else begin
            w_acc_next = r_acc;
          end
          w_last_beat = (r_beat == r_last);
        end else begin
          w_mem_size    = r_size;
          w_mem_sign    = r_sign;
          w_mem_address = r_addr;
          w_mem_wdata   = r_wdata;
          w_last_beat   = 1'b1;
        end
        w_state_next = w_last_beat ? S_RESP : S_ACCESS;
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Final load result; native loads are already extended by the memory.
  always_comb begin
    if (w_fault_next || r_write) begin
      w_result = {DATA_WIDTH{1'b0}};
    end else if (!r_byte_mode) begin
      w_result = i_mem_data_read;
    end else if (r_size == 2'b01) begin
      w_result = {{(DATA_WIDTH-16){r_sign & w_acc_next[15]}}, w_acc_next[15:0]};
    end else begin
      w_result = w_acc_next;
    end
  end

  // Request latch, beat bookkeeping and registered response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write     <= 1'b0;
      r_size      <= 2'b00;
      r_sign      <= 1'b0;
      r_addr      <= {DATA_WIDTH{1'b0}};
      r_wdata     <= {DATA_WIDTH{1'b0}};
      r_acc       <= {DATA_WIDTH{1'b0}};
      r_beat      <= 2'b00;
      r_last      <= 2'b00;
      r_byte_mode <= 1'b0;
      r_fault     <= 1'b0;
      r_rsp_rdata <= {DATA_WIDTH{1'b0}};
      r_rsp_fault <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_write     <= i_req_write;
            r_size      <= i_req_size;
            r_sign      <= i_req_sign_ext;
            r_addr      <= i_req_address;
            r_wdata     <= i_req_wdata;
            r_acc       <= {DATA_WIDTH{1'b0}};
            r_beat      <= 2'b00;
            r_fault     <= 1'b0;
            r_byte_mode <= ~w_req_aligned;
            r_last      <= w_req_aligned ? 2'd0 : ((i_req_size == 2'b01) ? 2'd1 : 2'd3);
            if (w_req_fault) begin
              r_rsp_rdata <= {DATA_WIDTH{1'b0}};
              r_rsp_fault <= 1'b1;
            end
          end
        end
        S_ACCESS: begin
          r_acc   <= w_acc_next;
          r_fault <= w_fault_next;
          r_beat  <= r_beat + 2'd1;
          if (w_last_beat) begin
            r_rsp_rdata <= w_result;
            r_rsp_fault <= w_fault_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_req_ready         = (r_state == S_IDLE);
  assign o_rsp_valid         = (r_state == S_RESP);
  assign o_rsp_rdata         = r_rsp_rdata;
  assign o_rsp_fault         = r_rsp_fault;
  assign o_mem_enable_write  = w_mem_en_w;
  assign o_mem_enable_read   = w_mem_en_r;
  assign o_mem_size          = w_mem_size;
  assign o_mem_sign_ext      = w_mem_sign;
  assign o_mem_address       = w_mem_address;
  assign o_mem_data_to_write = w_mem_wdata;

endmodule
